// File: rtl/execute_result_stage_pkg.sv
// Shared definitions for the execute result stage: branch condition codes,
// flag bit positions inside flags_q and the controller state encoding.
package execute_result_stage_pkg;

  localparam logic [3:0] COND_ALWAYS = 4'b0000;
  localparam logic [3:0] COND_ZS     = 4'b0001;
  localparam logic [3:0] COND_ZC     = 4'b0010;
  localparam logic [3:0] COND_CS     = 4'b0011;
  localparam logic [3:0] COND_CC     = 4'b0100;
  localparam logic [3:0] COND_SS     = 4'b0101;
  localparam logic [3:0] COND_SC     = 4'b0110;
  localparam logic [3:0] COND_VS     = 4'b0111;
  localparam logic [3:0] COND_VC     = 4'b1000;

  // flags_q layout is {carry, sign, overflow, zero}
  localparam int FLAG_CARRY = 3;
  localparam int FLAG_SIGN  = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 0;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] flags);
    logic taken;
    // NOTE: give every combinational result a default first so no path infers a latch.
    taken = 1'b0;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_ZS:     taken = flags[FLAG_ZERO];
      COND_ZC:     taken = ~flags[FLAG_ZERO];
      COND_CS:     taken = flags[FLAG_CARRY];
      COND_CC:     taken = ~flags[FLAG_CARRY];
      COND_SS:     taken = flags[FLAG_SIGN];
      COND_SC:     taken = ~flags[FLAG_SIGN];
      COND_VS:     taken = flags[FLAG_OVF];
      COND_VC:     taken = ~flags[FLAG_OVF];
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/execute_result_stage_wb_skid_buffer.sv
// Two-entry in-order write-back buffer; r_head is always the oldest entry so
// the read side is a plain register with no output mux.
module wb_skid_buffer #(
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop  & (r_count != 2'd0);
  assign w_push = i_push & (r_count != 2'd2);

  // NOTE: the entries are reset as well, because the head drives wb_data and must read zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments keep r_head <= r_tail a true shift of old values.
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_push_data;
          else                 r_tail <= i_push_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        // push and pop together only happen at occupancy 1: new data replaces the head
        2'b11: r_head <= i_push_data;
        default: ;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/execute_result_stage.sv
// Final execute stage: commits ALU flags, queues register write-backs and
// raises a one-cycle redirect for taken branches.
module execute_result_stage
  import execute_result_stage_pkg::*;
#(
  parameter int size        = 32,
  parameter int regAddrSize = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [size-1:0]        alu_result,
  input  logic                   carry_in,
  input  logic                   sign_in,
  input  logic                   overflow_in,
  input  logic                   zero_in,
  input  logic                   flag_we,
  input  logic                   reg_we,
  input  logic [regAddrSize-1:0] dest_reg,
  input  logic                   br_en,
  input  logic [3:0]             br_cond,
  input  logic [size-1:0]        br_target,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [size-1:0]        wb_data,
  output logic [regAddrSize-1:0] wb_reg,
  output logic [3:0]             flags_q,
  output logic                   redirect_valid,
  output logic [size-1:0]        redirect_pc
);

  localparam int ENTRY_W = size + regAddrSize;

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [3:0]       r_flags;
  logic [size-1:0]  r_redirect_pc;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_taken;
  logic [1:0]       w_fifo_count;
  logic [ENTRY_W-1:0] w_fifo_data;

  assign in_ready = (w_fifo_count < 2'd2) && (r_state == ST_RUN);
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & reg_we & ~br_en;
  assign w_pop    = wb_valid & wb_ready;

  // The condition sees the committed flags, not this op's own flag inputs.
  assign w_taken  = br_en & cond_taken(br_cond, r_flags);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (w_accept && w_taken) w_state_next = ST_FLUSH;
      ST_FLUSH: w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_flags       <= 4'b0000;
      r_redirect_pc <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept && flag_we) begin
        r_flags[FLAG_CARRY] <= carry_in;
        r_flags[FLAG_SIGN]  <= sign_in;
        r_flags[FLAG_OVF]   <= overflow_in;
        r_flags[FLAG_ZERO]  <= zero_in;
      end
      if (w_accept && w_taken) r_redirect_pc <= br_target;
    end
  end

  wb_skid_buffer #(
    .WIDTH (ENTRY_W)
  ) u_wb_skid_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data ({alu_result, dest_reg}),
    .i_pop       (w_pop),
    .o_valid     (wb_valid),
    .o_data      (w_fifo_data),
    .o_count     (w_fifo_count)
  );

  assign wb_data        = w_fifo_data[ENTRY_W-1:regAddrSize];
  assign wb_reg         = w_fifo_data[regAddrSize-1:0];
  assign flags_q        = r_flags;
  assign redirect_valid = (r_state == ST_FLUSH);
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_execute_result_stage.sv
// Bench for execute_result_stage: directed scenarios plus random traffic,
// checked every cycle against a behavioural model with a write-back queue.
module tb_execute_result_stage;

  localparam int SIZE = 32;
  localparam int RA   = 5;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] alu_result;
  logic            carry_in, sign_in, overflow_in, zero_in;
  logic            flag_we;
  logic            reg_we;
  logic [RA-1:0]   dest_reg;
  logic            br_en;
  logic [3:0]      br_cond;
  logic [SIZE-1:0] br_target;
  logic            wb_valid;
  logic            wb_ready;
  logic [SIZE-1:0] wb_data;
  logic [RA-1:0]   wb_reg;
  logic [3:0]      flags_q;
  logic            redirect_valid;
  logic [SIZE-1:0] redirect_pc;

  execute_result_stage #(.size(SIZE), .regAddrSize(RA)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_result     (alu_result),
    .carry_in       (carry_in),
    .sign_in        (sign_in),
    .overflow_in    (overflow_in),
    .zero_in        (zero_in),
    .flag_we        (flag_we),
    .reg_we         (reg_we),
    .dest_reg       (dest_reg),
    .br_en          (br_en),
    .br_cond        (br_cond),
    .br_target      (br_target),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_data        (wb_data),
    .wb_reg         (wb_reg),
    .flags_q        (flags_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vectors     = 0;
  int n_miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Independent reference for branch conditions; flags are {c, s, v, z}.
  function automatic bit bm_taken(input logic [3:0] c, input logic [3:0] f);
    case (c)
      4'd0: return 1'b1;
      4'd1: return f[0] == 1'b1;
      4'd2: return f[0] == 1'b0;
      4'd3: return f[3] == 1'b1;
      4'd4: return f[3] == 1'b0;
      4'd5: return f[2] == 1'b1;
      4'd6: return f[2] == 1'b0;
      4'd7: return f[1] == 1'b1;
      4'd8: return f[1] == 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  // Model state: expected write-back entries are pushed on acceptance and
  // popped when the register file consumes the head.
  logic [SIZE+RA-1:0] m_q[$];
  logic [3:0]         m_flags = 4'b0000;
  bit                 m_flush = 1'b0;
  logic [SIZE-1:0]    m_pc    = '0;
  bit                 m_ready, m_acc, m_pop, m_taken;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_flags = 4'b0000;
      m_flush = 1'b0;
      check("rst_flags", flags_q, 4'b0000);
      check("rst_wb_valid", wb_valid, 1'b0);
      check("rst_wb_data", wb_data, '0);
      check("rst_wb_reg", wb_reg, '0);
      check("rst_redirect_valid", redirect_valid, 1'b0);
      check("rst_redirect_pc", redirect_pc, '0);
    end else begin
      m_ready = (m_q.size() < 2) && !m_flush;
      check("in_ready", in_ready, m_ready);
      check("wb_valid", wb_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check("wb_data", wb_data, m_q[0][SIZE+RA-1:RA]);
        check("wb_reg", wb_reg, m_q[0][RA-1:0]);
      end
      check("redirect_valid", redirect_valid, m_flush);
      if (m_flush) check("redirect_pc", redirect_pc, m_pc);
      check("flags_q", flags_q, m_flags);

      m_acc   = in_valid && m_ready;
      m_pop   = (m_q.size() != 0) && wb_ready;
      m_taken = m_acc && br_en && bm_taken(br_cond, m_flags);
      if (m_pop) void'(m_q.pop_front());
      if (m_acc && reg_we && !br_en) m_q.push_back({alu_result, dest_reg});
      if (m_flush) m_flush = 1'b0;
      else if (m_taken) begin
        m_flush = 1'b1;
        m_pc    = br_target;
      end
      if (m_acc && flag_we) m_flags = {carry_in, sign_in, overflow_in, zero_in};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rw, input logic fw, input logic be, input logic [3:0] cond,
                        input logic [SIZE-1:0] data, input logic [RA-1:0] rd,
                        input logic [3:0] flg, input logic [SIZE-1:0] tgt);
    in_valid   = 1'b1;
    reg_we     = rw;
    flag_we    = fw;
    br_en      = be;
    br_cond    = cond;
    alu_result = data;
    dest_reg   = rd;
    {carry_in, sign_in, overflow_in, zero_in} = flg;
    br_target  = tgt;
  endtask

  // Hold the current op until the stage takes it, bounded to 20 cycles.
  task automatic wait_accept();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      step();
    end
    check("accept_timeout", done, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic push_wb(input logic [SIZE-1:0] data, input logic [RA-1:0] rd);
    set_op(1'b1, 1'b0, 1'b0, 4'd0, data, rd, 4'b0000, '0);
    wait_accept();
  endtask

  task automatic set_flags(input logic [3:0] flg);
    set_op(1'b0, 1'b1, 1'b0, 4'd0, '0, '0, flg, '0);
    wait_accept();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit exp_t;
    rst_n = 1'b0;
    wb_ready = 1'b1;
    // Reset held while an op is offered: nothing may be taken in.
    set_op(1'b1, 1'b1, 1'b1, 4'd0, 32'hDEAD_BEEF, 5'd3, 4'b1111, 32'h100);
    repeat (3) step();
    check("hold_rst_flags", flags_q, 4'b0000);
    check("hold_rst_wb_valid", wb_valid, 1'b0);
    check("hold_rst_redirect", redirect_valid, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("ready_at_release", in_ready, 1'b1);
    step();
    check("ready_after_rst", in_ready, 1'b1);

    // Flag update followed by a dependent branch.
    set_flags(4'b0001);
    check("flags_zero", flags_q, 4'b0001);
    set_op(1'b0, 1'b0, 1'b1, 4'b0001, '0, '0, 4'b0000, 32'h0000_4000);
    wait_accept();
    check("redir_pulse", redirect_valid, 1'b1);
    check("redir_pc", redirect_pc, 32'h0000_4000);
    check("ready_in_flush", in_ready, 1'b0);
    step();
    check("redir_one_cycle", redirect_valid, 1'b0);
    check("ready_after_flush", in_ready, 1'b1);

    // Same-cycle flag write must not feed its own branch.
    set_flags(4'b0000);
    set_op(1'b0, 1'b1, 1'b1, 4'b0001, '0, '0, 4'b0001, 32'h0000_8000);
    wait_accept();
    check("same_cycle_no_redir", redirect_valid, 1'b0);
    check("same_cycle_flags", flags_q, 4'b0001);
    step();
    check("same_cycle_no_redir2", redirect_valid, 1'b0);

    // Backpressure with three write-backs.
    wb_ready = 1'b0;
    push_wb(32'h11, 5'd1);
    push_wb(32'h22, 5'd2);
    check("bp_full_ready", in_ready, 1'b0);
    set_op(1'b1, 1'b0, 1'b0, 4'd0, 32'h33, 5'd3, 4'b0000, '0);
    repeat (2) step();
    check("bp_stall_ready", in_ready, 1'b0);
    check("bp_head_11", wb_data, 32'h11);
    check("bp_head_reg1", wb_reg, 5'd1);
    wb_ready = 1'b1;
    step();
    check("bp_head_22", wb_data, 32'h22);
    check("bp_ready_again", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("bp_head_33", wb_data, 32'h33);
    check("bp_valid_33", wb_valid, 1'b1);
    step();
    check("bp_drained", wb_valid, 1'b0);

    // Simultaneous push and pop at occupancy 1.
    wb_ready = 1'b0;
    push_wb(32'h55, 5'd5);
    wb_ready = 1'b1;
    set_op(1'b1, 1'b0, 1'b0, 4'd0, 32'h66, 5'd6, 4'b0000, '0);
    step();
    check("pp_valid", wb_valid, 1'b1);
    check("pp_head_66", wb_data, 32'h66);
    check("pp_ready", in_ready, 1'b1);
    set_op(1'b1, 1'b0, 1'b0, 4'd0, 32'h77, 5'd7, 4'b0000, '0);
    step();
    in_valid = 1'b0;
    check("pp_head_77", wb_data, 32'h77);
    check("pp_reg_7", wb_reg, 5'd7);
    step();
    check("pp_drained", wb_valid, 1'b0);

    // Condition-code sweep over two complementary flag patterns.
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 16; c++) begin
        logic [3:0] pat;
        pat = (p == 0) ? 4'b1010 : 4'b0101;
        set_flags(pat);
        set_op(1'b0, 1'b0, 1'b1, 4'(c), '0, '0, 4'b0000, 32'h1000 + 32'(c));
        wait_accept();
        exp_t = bm_taken(4'(c), pat);
        check("cond_taken", redirect_valid, exp_t);
        step();
        check("cond_redir_end", redirect_valid, 1'b0);
      end
    end

    // Reset with a full buffer.
    wb_ready = 1'b0;
    push_wb(32'hA1, 5'd10);
    push_wb(32'hA2, 5'd11);
    check("full_valid", wb_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("full_rst_valid", wb_valid, 1'b0);
    check("full_rst_data", wb_data, '0);
    check("full_rst_reg", wb_reg, '0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Reset in the middle of a flush with a pending write-back.
    push_wb(32'hB1, 5'd12);
    set_op(1'b0, 1'b0, 1'b1, 4'd0, '0, '0, 4'b0000, 32'h1234_5678);
    wait_accept();
    check("mid_flush_redir", redirect_valid, 1'b1);
    check("mid_flush_pc", redirect_pc, 32'h1234_5678);
    check("mid_flush_wb", wb_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("flush_rst_redir", redirect_valid, 1'b0);
    check("flush_rst_pc", redirect_pc, '0);
    check("flush_rst_wb", wb_valid, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("post_rst_redir", redirect_valid, 1'b0);
    check("post_rst_wb", wb_valid, 1'b0);

    // Random traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 400; i++) begin
      set_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
             32'($urandom), 5'($urandom_range(0, 31)),
             4'($urandom_range(0, 15)), 32'($urandom));
      in_valid = 1'($urandom_range(0, 1));
      wb_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    in_valid = 1'b0;
    wb_ready = 1'b1;
    repeat (4) step();
    check("final_drained", wb_valid, 1'b0);
    check("final_no_redir", redirect_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
